fir_seq: RTL and testbench
==========================

Name: fir_seq

Overview:
- FIR tap sequencer and multiply-accumulate engine that sits directly downstream of dag.
- Programs two dag circular buffers: CB0 holds the sample delay line, CB1 holds the coefficients.
- For each input sample it writes the sample into data memory, then issues alternating sample/coefficient reads through dag.
- It accumulates the products and emits one saturated Q15 output per input.

Parameters:
- TAPS, 16, filter length (2..256).
- SAMP_BASE, 16'h0000, base address of the sample ring; SAMP_BASE+TAPS must not exceed 16'hFFFF.
- COEF_BASE, 16'h0100, base address of the coefficient table; COEF_BASE+k holds h[TAPS-1-k].
- ACCW, 40, accumulator width; must be at least 32+clog2(TAPS).

Ports:
- clk  in  1  clock
- rst  in  1  reset: asynchronous, active-high
- in_valid  in  1  input sample offered
- in_ready  out  1  block can accept a sample
- in_sample  in  16  signed Q15 sample
- out_valid  out  1  one-cycle result strobe
- out_data  out  16  signed Q15 result, held until the next strobe
- dag_re  out  1  dag read-enable
- dag_we  out  1  dag write-enable
- dag_cbs  out  3  dag buffer select
- dag_base  out  16  dag base address
- dag_len  out  12  dag length
- dag_sign  out  1  dag direction; always 0
- dag_expt  out  3  dag exponent; always 0
- mem_we  out  1  data memory write strobe; address is dag's a output
- mem_wdata  out  16  data memory write data
- mem_q  in  16  synchronous memory read data, valid 1 cycle after address

Behaviour:
- Reset values: all outputs 0, state CFG0, accumulator 0.
- Reset asserted mid-operation aborts immediately; no partial out_valid is produced.
- dag has no reset, so the full CFG/CLR sequence reruns after every reset.
- CFG0, 1 cycle: dag_we=1, cbs=0, base=SAMP_BASE, len=TAPS.
- CFG1, 1 cycle: dag_we=1, cbs=1, base=COEF_BASE, len=TAPS.
- CLR, TAPS cycles: dag_re=1, cbs=0. Each following cycle drives mem_we=1, mem_wdata=0, zero-filling the ring. The CB0 pointer returns to SAMP_BASE.
- CLR is followed by one drain cycle, then IDLE.
- IDLE: in_ready=1. A handshake (in_valid & in_ready) on cycle 0 latches in_sample and clears the accumulator.
- WR, cycle 1: dag_re=1, cbs=0 yields write address p on a at cycle 2.
- Cycle 2: mem_we=1, mem_wdata=latched sample.
- RD, cycles 2..2*TAPS+1: dag_re=1 every cycle. cbs alternates 0,1,0,1…, starting with 0.
- Samples come back oldest-first: x[n-TAPS+1] … x[n], addresses p+1 … p+TAPS (wraps to p). Coefficients come back h[TAPS-1] … h[0].
- Read at cycle t: address at t+1, mem_q at t+2.
- Pipeline control is a 2-bit valid/kind shift register tracking each read.
- Sample mem_q is registered. On the following coefficient mem_q, the 16x16 signed product is registered 1 cycle later; acc += sign-extended product 1 cycle after that.
- Last coefficient mem_q at cycle 2*TAPS+3; product at 2*TAPS+4; final acc at 2*TAPS+5.
- Cycle 2*TAPS+6: out_valid=1 and out_data = sat16(acc >>> 15).
- Shift is arithmetic (floor). Saturation: results >32767 give 16'h7FFF; results <-32768 give 16'h8000.
- The state returns to IDLE in the out_valid cycle, so in_ready=1 there. Throughput is one sample per 2*TAPS+6 cycles minimum.
- in_valid while in_ready=0 is ignored; the source must hold the sample.
- After each sample the CB0 pointer sits at p+1, the oldest entry, which is exactly the next write slot. The CB1 pointer returns to COEF_BASE.
- No backpressure on output; out_data is overwritten by the next result.

Decomposition:
- fir_pkg holds:
  - state enum: CFG0, CFG1, CLR, CLR_DRAIN, IDLE, WR, RD, DRAIN;
  - constants CBS_SAMP=3'd0, CBS_COEF=3'd1, FRAC=15, Q15_MAX, Q15_MIN.
- One sub-module, fir_mac: sample register, product register, ACCW accumulator with clear, arithmetic shift and saturation. Its interface is clr, smp_v, coef_v, d, and the result.
- The FSM, counters and dag/memory drive stay in fir_seq.

Test Plan:
- Reset release -> CFG0 then CFG1 with (cbs, base, len) = (0,SAMP_BASE,TAPS), (1,COEF_BASE,TAPS). Then TAPS zero writes, then in_ready=1.
- Impulse response (TAPS=4, COEF table 0x0800,0x1000,0x2000,0x4000, i.e. h0=0x4000): inputs 0x7FFF,0,0,0,0 -> outputs 0x3FFF,0x1FFF,0x0FFF,0x07FF,0x0000.
- Latency: checked on the impulse stimulus; out_valid exactly 2*TAPS+6 = 14 cycles after the handshake; in_ready low for the intervening cycles.
- Zero-fill check (all h=0x7FFF): the first sample after reset, 0x1000 -> 0x0FFF.
- Saturation (all h=0x7FFF): four inputs of 0x7FFF -> fourth output 0x7FFF. Then four inputs of 0x8000 -> fourth output 0x8000.
- Delay-line wrap: ramp 1..12 (Q15 ints) with all h=0x2000 -> output k >= 4 equals floor((k+(k-1)+(k-2)+(k-3))/4), i.e. ring wrap is correct over more than 2*TAPS samples.
- Reset mid-operation: assert rst during RD -> no out_valid. Release -> full CFG/CLR rerun; the next impulse reproduces the impulse-response results.

Source files
------------

// File: rtl/fir_pkg.sv
// fir_pkg: shared types and constants for the FIR tap sequencer.
//   state_t      - sequencer states, from dag configuration through one filter pass
//   CBS_SAMP/COEF - dag buffer selects for the sample ring and the coefficient table
//   FRAC          - Q15 fraction bits dropped from the accumulator on output
//   Q15_MAX/MIN   - saturation limits of the 16-bit result
//   DRAIN_CYCLES  - cycles from the last read to the output strobe (exclusive)
package fir_pkg;

  typedef enum logic [2:0] {
    CFG0,
    CFG1,
    CLR,
    CLR_DRAIN,
    IDLE,
    WR,
    RD,
    DRAIN
  } state_t;

  localparam logic [2:0] CBS_SAMP = 3'd0;
  localparam logic [2:0] CBS_COEF = 3'd1;

  localparam int FRAC    = 15;
  localparam int Q15_MAX = 32767;
  localparam int Q15_MIN = -32768;

  // Last read issues at 2*TAPS+1; mem_q +2, product +1, accumulate +1,
  // strobe registered one cycle after that.
  localparam int DRAIN_CYCLES = 4;

endpackage

// File: rtl/fir_mac.sv
// fir_mac: multiply-accumulate datapath behind the tap sequencer.
//   clk, rst  - clock, asynchronous active-high reset
//   clr       - clears the accumulator (start of a new output)
//   smp_v     - d carries a delay-line sample this cycle
//   coef_v    - d carries the coefficient pairing with the held sample
//   d         - synchronous memory read data
//   result    - sat16(acc >>> FRAC), combinational from the accumulator
module fir_mac
  import fir_pkg::*;
#(
  parameter int ACCW = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        smp_v,
  input  logic        coef_v,
  input  logic [15:0] d,
  output logic [15:0] result
);

  localparam logic signed [ACCW-1:0] SAT_HI = ACCW'(Q15_MAX);
  localparam logic signed [ACCW-1:0] SAT_LO = ACCW'(Q15_MIN);

  logic signed [15:0]     r_smp;
  logic signed [31:0]     r_prod;
  logic                   r_prodV;
  logic signed [ACCW-1:0] r_acc;
  logic signed [31:0]     w_prod;
  logic signed [ACCW-1:0] w_shift;

  assign w_prod = 32'(r_smp) * 32'($signed(d));

  // Sample is held until its coefficient arrives on the next read slot;
  // the product is registered and added one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_smp   <= '0;
      r_prod  <= '0;
      r_prodV <= 1'b0;
      r_acc   <= '0;
    end else begin
      if (smp_v) begin
        r_smp <= d;
      end
      if (clr) begin
        r_prodV <= 1'b0;
        r_acc   <= '0;
      end else begin
        r_prodV <= coef_v;
        if (coef_v) begin
          r_prod <= w_prod;
        end
        if (r_prodV) begin
          r_acc <= r_acc + ACCW'(r_prod);
        end
      end
    end
  end

  // Arithmetic shift floors toward minus infinity before saturation.
  assign w_shift = r_acc >>> FRAC;

  always_comb begin
    if (w_shift > SAT_HI) begin
      result = 16'h7FFF;
    end else if (w_shift < SAT_LO) begin
      result = 16'h8000;
    end else begin
      result = w_shift[15:0];
    end
  end

endmodule

// File: rtl/fir_seq.sv
// fir_seq: FIR tap sequencer driving a dag address generator and a
// synchronous data memory, with a saturating Q15 MAC.
//   clk, rst            - clock, asynchronous active-high reset
//   in_valid/in_ready   - input sample handshake; in_sample is signed Q15
//   out_valid/out_data  - one-cycle result strobe, data held until the next
//   dag_re/we/cbs/base/len/sign/expt - dag control (sign and expt tied 0)
//   mem_we/mem_wdata    - memory write, address comes from dag
//   mem_q               - memory read data, one cycle after the dag address
module fir_seq
  import fir_pkg::*;
#(
  parameter int          TAPS      = 16,
  parameter logic [15:0] SAMP_BASE = 16'h0000,
  parameter logic [15:0] COEF_BASE = 16'h0100,
  parameter int          ACCW      = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_sample,
  output logic        out_valid,
  output logic [15:0] out_data,
  output logic        dag_re,
  output logic        dag_we,
  output logic [2:0]  dag_cbs,
  output logic [15:0] dag_base,
  output logic [11:0] dag_len,
  output logic        dag_sign,
  output logic [2:0]  dag_expt,
  output logic        mem_we,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_q
);

  localparam int CW = $clog2(2 * TAPS) + 1;
  localparam logic [CW-1:0] CLR_LAST   = CW'(TAPS - 1);
  localparam logic [CW-1:0] RD_LAST    = CW'(2 * TAPS - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYCLES - 1);

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [15:0]   r_inSample;
  logic          r_wrPend;
  logic          r_clrPend;
  logic [1:0]    r_pipe1;
  logic [1:0]    r_pipe2;
  logic          r_outValid;
  logic [15:0]   r_outData;
  logic          w_hs;
  logic          w_outFire;
  logic          w_smpV;
  logic          w_coefV;
  logic [15:0]   w_result;

  assign in_ready  = (r_state == IDLE);
  assign w_hs      = in_valid & in_ready;
  assign w_outFire = (r_state == DRAIN) && (r_cnt == DRAIN_LAST);

  always_comb begin
    w_next = r_state;
    case (r_state)
      CFG0:      w_next = CFG1;
      CFG1:      w_next = CLR;
      CLR:       if (r_cnt == CLR_LAST) w_next = CLR_DRAIN;
      CLR_DRAIN: w_next = IDLE;
      IDLE:      if (w_hs) w_next = WR;
      WR:        w_next = RD;
      RD:        if (r_cnt == RD_LAST) w_next = DRAIN;
      DRAIN:     if (r_cnt == DRAIN_LAST) w_next = IDLE;
      default:   w_next = CFG0;
    endcase
  end

  // The reset state is CFG0, so the dag drive is gated by rst to keep
  // every output low while reset is held.
  always_comb begin
    dag_re   = 1'b0;
    dag_we   = 1'b0;
    dag_cbs  = CBS_SAMP;
    dag_base = '0;
    dag_len  = '0;
    if (!rst) begin
      case (r_state)
        CFG0: begin
          dag_we   = 1'b1;
          dag_base = SAMP_BASE;
          dag_len  = 12'(TAPS);
        end
        CFG1: begin
          dag_we   = 1'b1;
          dag_cbs  = CBS_COEF;
          dag_base = COEF_BASE;
          dag_len  = 12'(TAPS);
        end
        CLR, WR: begin
          dag_re = 1'b1;
        end
        RD: begin
          dag_re  = 1'b1;
          dag_cbs = r_cnt[0] ? CBS_COEF : CBS_SAMP;
        end
        default: ;
      endcase
    end
  end

  assign dag_sign  = 1'b0;
  assign dag_expt  = 3'd0;
  assign mem_we    = r_wrPend | r_clrPend;
  assign mem_wdata = r_wrPend ? r_inSample : 16'h0000;

  // Counter restarts on every state change; each counted state is
  // entered from a different state, so it always starts at zero.
  // The pipe tracks {valid, is-coefficient} for each RD read until its
  // data appears on mem_q two cycles later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= CFG0;
      r_cnt      <= '0;
      r_inSample <= '0;
      r_wrPend   <= 1'b0;
      r_clrPend  <= 1'b0;
      r_pipe1    <= '0;
      r_pipe2    <= '0;
      r_outValid <= 1'b0;
      r_outData  <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_hs) begin
        r_inSample <= in_sample;
      end
      r_wrPend   <= (r_state == WR);
      r_clrPend  <= (r_state == CLR);
      r_pipe1    <= {r_state == RD, r_cnt[0]};
      r_pipe2    <= r_pipe1;
      r_outValid <= w_outFire;
      if (w_outFire) begin
        r_outData <= w_result;
      end
    end
  end

  assign w_smpV    = r_pipe2[1] & ~r_pipe2[0];
  assign w_coefV   = r_pipe2[1] & r_pipe2[0];
  assign out_valid = r_outValid;
  assign out_data  = r_outData;

  fir_mac #(
    .ACCW(ACCW)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .clr   (w_hs),
    .smp_v (w_smpV),
    .coef_v(w_coefV),
    .d     (mem_q),
    .result(w_result)
  );

endmodule

// File: tb/tb_fir_seq.sv
// tb_fir_seq: directed bench for fir_seq with TAPS=4. Models the dag
// circular buffers and a synchronous memory; expected outputs are hand
// computed Q15 results.
module tb_fir_seq;

  logic        clk;
  logic        rst;
  logic        inValid;
  logic        inReady;
  logic [15:0] inSample;
  logic        outValid;
  logic [15:0] outData;
  logic        dagRe;
  logic        dagWe;
  logic [2:0]  dagCbs;
  logic [15:0] dagBase;
  logic [11:0] dagLen;
  logic        dagSign;
  logic [2:0]  dagExpt;
  logic        memWe;
  logic [15:0] memWdata;
  logic [15:0] memQ;

  logic [15:0] cbBase [0:7];
  logic [11:0] cbLen  [0:7];
  logic [15:0] cbPtr  [0:7];
  logic [15:0] dagA;
  logic [15:0] mem [0:511];
  logic        pokeEn;
  logic [8:0]  pokeAddr;
  logic [15:0] pokeData;

  int vecCount;
  int missCount;

  logic [15:0] impIn   [0:4]  = '{16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
  logic [15:0] impOut  [0:4]  = '{16'h3FFF, 16'h1FFF, 16'h0FFF, 16'h07FF, 16'h0000};
  logic [15:0] satIn   [0:7]  = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF,
                                  16'h8000, 16'h8000, 16'h8000, 16'h8000};
  logic [15:0] satOut  [0:7]  = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF,
                                  16'h7FFF, 16'hFFFE, 16'h8000, 16'h8000};
  logic [15:0] rampExp [0:11] = '{16'd0, 16'd0, 16'd1, 16'd2, 16'd3, 16'd4,
                                  16'd5, 16'd6, 16'd7, 16'd8, 16'd9, 16'd10};

  fir_seq #(
    .TAPS     (4),
    .SAMP_BASE(16'h0000),
    .COEF_BASE(16'h0100),
    .ACCW     (40)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (inValid),
    .in_ready (inReady),
    .in_sample(inSample),
    .out_valid(outValid),
    .out_data (outData),
    .dag_re   (dagRe),
    .dag_we   (dagWe),
    .dag_cbs  (dagCbs),
    .dag_base (dagBase),
    .dag_len  (dagLen),
    .dag_sign (dagSign),
    .dag_expt (dagExpt),
    .mem_we   (memWe),
    .mem_wdata(memWdata),
    .mem_q    (memQ)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // dag model: a read presents the current pointer on dagA next cycle and
  // post-increments the selected buffer pointer with wrap at base+len.
  always @(posedge clk) begin
    if (dagWe) begin
      cbBase[dagCbs] <= dagBase;
      cbLen[dagCbs]  <= dagLen;
      cbPtr[dagCbs]  <= dagBase;
    end else if (dagRe) begin
      dagA <= cbPtr[dagCbs];
      if (cbPtr[dagCbs] + 16'd1 == cbBase[dagCbs] + {4'd0, cbLen[dagCbs]}) begin
        cbPtr[dagCbs] <= cbBase[dagCbs];
      end else begin
        cbPtr[dagCbs] <= cbPtr[dagCbs] + 16'd1;
      end
    end
  end

  // Synchronous memory addressed by dagA; the bench can poke it directly.
  always @(posedge clk) begin
    if (pokeEn) begin
      mem[pokeAddr] <= pokeData;
    end else if (memWe) begin
      mem[dagA[8:0]] <= memWdata;
    end
    memQ <= mem[dagA[8:0]];
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic pokeMem(input logic [8:0] addr, input logic [15:0] data);
    @(negedge clk);
    pokeEn   = 1'b1;
    pokeAddr = addr;
    pokeData = data;
    @(negedge clk);
    pokeEn = 1'b0;
  endtask

  // Coefficients in address order: COEF_BASE+0 holds h[3].
  task automatic loadCoefs(input logic [15:0] c0, input logic [15:0] c1,
                           input logic [15:0] c2, input logic [15:0] c3);
    pokeMem(9'h100, c0);
    pokeMem(9'h101, c1);
    pokeMem(9'h102, c2);
    pokeMem(9'h103, c3);
  endtask

  task automatic resetDut(input string tag);
    int n;
    int zeroWrites;
    bit sawValid;
    @(negedge clk);
    rst     = 1'b1;
    inValid = 1'b0;
    #1;
    checkOutput({tag, "_rstout"},
                {inReady, outValid, outData, dagRe, dagWe, dagLen, dagBase, memWe, dagCbs},
                64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput({tag, "_cfg0"}, {dagWe, dagRe, dagCbs, dagBase, dagLen},
                {1'b1, 1'b0, 3'd0, 16'h0000, 12'd4});
    @(negedge clk);
    checkOutput({tag, "_cfg1"}, {dagWe, dagRe, dagCbs, dagBase, dagLen},
                {1'b1, 1'b0, 3'd1, 16'h0100, 12'd4});
    n          = 0;
    zeroWrites = 0;
    sawValid   = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (memWe && memWdata == 16'h0000) zeroWrites++;
      if (outValid) sawValid = 1'b1;
    end while (!inReady && n < 30);
    checkOutput({tag, "_clrlen"}, n, 6);
    checkOutput({tag, "_zwrites"}, zeroWrites, 4);
    checkOutput({tag, "_novalid"}, sawValid, 0);
    checkOutput({tag, "_zfill"}, {mem[0], mem[1], mem[2], mem[3]}, 64'd0);
  endtask

  task automatic applyStimulus(input string tag, input logic [15:0] sample,
                               input logic [15:0] expected, input bit checkLat);
    int n;
    bit sawReady;
    n = 0;
    while (!inReady && n < 60) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_rdy"}, inReady, 1);
    inValid  = 1'b1;
    inSample = sample;
    @(negedge clk);
    inValid  = 1'b0;
    inSample = 16'hA5A5;
    checkOutput({tag, "_pulse"}, outValid, 0);
    n        = 1;
    sawReady = 1'b0;
    while (!outValid && n < 60) begin
      if (inReady) sawReady = 1'b1;
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_valid"}, outValid, 1);
    checkOutput({tag, "_data"}, outData, expected);
    if (checkLat) begin
      checkOutput({tag, "_lat"}, n, 14);
      checkOutput({tag, "_busy"}, sawReady, 0);
      checkOutput({tag, "_rdyout"}, inReady, 1);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    vecCount  = 0;
    missCount = 0;
    rst       = 1'b1;
    inValid   = 1'b0;
    inSample  = 16'h0000;
    pokeEn    = 1'b0;
    pokeAddr  = '0;
    pokeData  = '0;

    loadCoefs(16'h0800, 16'h1000, 16'h2000, 16'h4000);
    resetDut("rst1");
    for (int k = 0; k < 5; k++) begin
      applyStimulus($sformatf("imp%0d", k), impIn[k], impOut[k], k == 0);
    end

    for (int k = 0; k < 4; k++) begin
      pokeMem(9'(k), 16'h5555);
    end
    loadCoefs(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    resetDut("rst2");
    applyStimulus("zfill", 16'h1000, 16'h0FFF, 1'b0);
    for (int k = 0; k < 8; k++) begin
      applyStimulus($sformatf("sat%0d", k), satIn[k], satOut[k], 1'b0);
    end

    loadCoefs(16'h2000, 16'h2000, 16'h2000, 16'h2000);
    resetDut("rst3");
    for (int k = 1; k <= 12; k++) begin
      applyStimulus($sformatf("ramp%0d", k), 16'(k), rampExp[k-1], 1'b0);
    end

    loadCoefs(16'h0800, 16'h1000, 16'h2000, 16'h4000);
    n = 0;
    while (!inReady && n < 60) begin
      @(negedge clk);
      n++;
    end
    inValid  = 1'b1;
    inSample = 16'h7FFF;
    @(negedge clk);
    inValid = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("mid_rd", {inReady, dagRe}, {1'b0, 1'b1});
    resetDut("rst4");
    for (int k = 0; k < 5; k++) begin
      applyStimulus($sformatf("reimp%0d", k), impIn[k], impOut[k], k == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
